// File: rtl/point_reader.sv
// point_reader: walks a completed point table (N entries of x word + y word)
// through a 1-cycle-latency read port. Each point is emitted on a
// valid/ready stream with its index and a last flag. An unsigned bounding
// box of all emitted points is accumulated and presented with done.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start              pulse, begins a scan when src_complete is high
//   src_complete       level, table fully written; dropping it mid-scan aborts
//   rd_en, rd_addr     table read strobe and index
//   rd_x, rd_y         table read data, valid the cycle after rd_en
//   out_valid/ready    stream handshake
//   out_idx/x/y/last   stream payload
//   busy, done         scan in progress / scan finished with bbox valid
//   aborted            one-cycle pulse when a scan is aborted
//   min_x..max_y       unsigned bounding box
module point_reader #(
    parameter int unsigned N  = 64,
    parameter int unsigned AW = 6,
    parameter int unsigned XW = 32,
    parameter int unsigned YW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          src_complete,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [XW-1:0] rd_x,
    input  logic [31:0]   rd_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [XW-1:0] min_x,
    output logic [XW-1:0] max_x,
    output logic [YW-1:0] min_y,
    output logic [YW-1:0] max_y
);

    localparam logic [AW-1:0] LastIdx = AW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StSend,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic          accept;
    logic          abort;
    logic          handshake;
    logic [YW-1:0] y_val;

    // Only the low YW bits of the y word carry data.
    logic unused_rd_y;
    assign unused_rd_y = ^rd_y;
    assign y_val       = rd_y[YW-1:0];

    assign rd_en = (state_q == StFetch);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        abort     = 1'b0;
        handshake = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start && src_complete) begin
                    accept  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!src_complete) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!src_complete) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StSend;
                end
            end
            StSend: begin
                // Abort wins over a simultaneous handshake.
                if (!src_complete) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (out_valid && out_ready) begin
                    handshake = 1'b1;
                    state_d   = (rd_addr == LastIdx) ? StDone : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            min_x     <= '1;
            max_x     <= '0;
            min_y     <= '1;
            max_y     <= '0;
        end else begin
            aborted <= 1'b0;

            if (accept) begin
                rd_addr <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
                min_x   <= '1;
                max_x   <= '0;
                min_y   <= '1;
                max_y   <= '0;
            end

            if (abort) begin
                // Bbox is left with its partial values.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                aborted   <= 1'b1;
            end else if (state_q == StWait) begin
                out_x     <= rd_x;
                out_y     <= y_val;
                out_idx   <= rd_addr;
                out_last  <= (rd_addr == LastIdx);
                out_valid <= 1'b1;
                if (rd_x < min_x) min_x <= rd_x;
                if (rd_x > max_x) max_x <= rd_x;
                if (y_val < min_y) min_y <= y_val;
                if (y_val > max_y) max_y <= y_val;
            end else if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (rd_addr == LastIdx) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/point_reader.md
Name: point_reader

Overview:
- Consumer of the random point table filled by the point generator (64 x-words, 64 y-values, plus a `complete` flag).
- Once the table is complete and `start` is pulsed, the block walks entries 0..N-1 over a 1-cycle-latency read port.
- Each point is emitted on a valid/ready stream with index and last flag.
- An unsigned bounding box (min/max of x and y) is accumulated and presented with `done`.
- Feeds the plotting/display path.

Parameters:
- N, 64, number of points in the table.
- AW, 6, index/address width; must satisfy 2^AW >= N.
- XW, 32, x coordinate width.
- YW, 8, significant y width; the low YW bits of the y word are used.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begins a scan.
- src_complete  in  1  point table fully written; level.
- rd_en  out  1  read strobe for the point table.
- rd_addr  out  AW  read index.
- rd_x  in  XW  x word; valid the cycle after rd_en.
- rd_y  in  32  y word; valid the cycle after rd_en; only [YW-1:0] used.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts.
- out_idx  out  AW  point index.
- out_x  out  XW  x coordinate.
- out_y  out  YW  y coordinate.
- out_last  out  1  high with out_valid when out_idx == N-1.
- busy  out  1  scan in progress.
- done  out  1  level; scan finished, bbox valid.
- aborted  out  1  one-cycle pulse on abort.
- min_x, max_x  out  XW  x bounding box.
- min_y, max_y  out  YW  y bounding box.

Behaviour:
- Reset values:
  - state IDLE.
  - All strobes, flags and stream outputs = 0: rd_en, rd_addr, out_valid, out_idx, out_x, out_y, out_last, busy, done, aborted.
  - min_x = all ones, max_x = 0, min_y = all ones, max_y = 0.
- Reset has priority over everything, including mid-scan and mid-handshake.
- FSM states: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE/DONE:
  - start & src_complete -> FETCH.
  - On that edge: rd_addr <= 0, busy <= 1, done <= 0, bbox reloaded to its reset values.
  - start with src_complete low is ignored; state unchanged.
- FETCH:
  - rd_en = 1 for exactly this one cycle, with rd_addr = current index.
  - Next state WAIT.
- WAIT:
  - rd_x/rd_y are captured into out_x/out_y (y truncated to YW bits) and out_idx <= rd_addr.
  - out_last <= (rd_addr == N-1); out_valid <= 1.
  - bbox updated with unsigned compares: min <= value < min ? value : min, and likewise for max.
  - Next state SEND.
- SEND:
  - out_x, out_y, out_idx and out_last are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid <= 0, out_last <= 0.
  - If the index was N-1: busy <= 0, done <= 1, next state DONE.
  - Otherwise: rd_addr <= rd_addr + 1, next state FETCH.
- Timing:
  - out_valid first rises 2 edges after the edge that samples start.
  - With out_ready held high, each point takes 3 cycles.
  - done rises 3N edges after the start edge.
- rd_addr never exceeds N-1; no wrap.
- start while busy is ignored.
- Abort: src_complete low in FETCH, WAIT or SEND.
  - Next edge: state IDLE; out_valid, out_last, busy = 0; done stays 0; aborted = 1 for one cycle.
  - bbox holds its partial values; it is not meaningful.
- Simultaneous out_ready handshake and src_complete drop: abort wins; the handshake still counts as consumed downstream.
- A start in DONE restarts the scan and clears done on the accepting edge.

Test Plan:
- Load x[i] = 1000+i, y[i] = 200-i, src_complete = 1, out_ready = 1, pulse start:
  - 64 beats in order idx 0..63; out_last only on idx 63.
  - done rises 192 cycles after start.
  - min_x = 1000, max_x = 1063, min_y = 137, max_y = 200.
- Same table, out_ready toggled randomly (30% high):
  - Data held stable under stall; no beat lost or duplicated.
  - Exactly one rd_en per index.
- Pulse start with src_complete = 0:
  - No rd_en; busy, out_valid and done stay 0.
- Mid-scan at idx 20 with out_valid high, drop src_complete:
  - Next cycle out_valid = 0, busy = 0, aborted pulses once, done = 0.
  - Restart completes normally from idx 0.
- Assert rst during SEND at idx 5:
  - All outputs return to reset values, including min_x = 0xFFFFFFFF and max_x = 0.
  - No further rd_en.
- Y word 0x000001FF with XW = 32 and x = 0xFFFFFFFF:
  - out_y = 0xFF; max_x = 0xFFFFFFFF.
- After done, pulse start again with a new table:
  - done drops on the accepting edge and the bbox is rebuilt.
